// File: rtl/timer_sched_pkg.sv
// Shared types and sizing helpers for the timer_scheduler block.
package timer_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  localparam int TICKS_100NS = 10;

  // Counter width large enough to hold (2^w - 1) * ticks without truncation.
  function automatic int cnt_width(input int w, input int ticks);
    return w + $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/timer_scheduler_interval_timer.sv
// Shared interval counter: load starts at 1, en advances, fin flags terminal count.
module interval_timer
  import timer_sched_pkg::*;
#(
  parameter int CW = cnt_width(4, TICKS_100NS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] target,
  input  logic          load,
  input  logic          en,
  output logic          fin
);

  logic [CW-1:0] count;
  logic [CW-1:0] tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= CW'(1);
    else if (en)
      count <= count + CW'(1);
  end

  // Target is only meaningful after a load, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load)
      tgt <= target;
  end

  assign fin = (count == tgt);

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin owner of one shared interval timer for NREQ requesters.
// Optional TIMER_SCHED_ABORT_EN: a granted requester dropping req mid-RUN aborts the interval.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int W              = 4,
  parameter int TICKS_PER_UNIT = TICKS_100NS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       dur,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic [$clog2(NREQ)-1:0] active_id,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_width(W, TICKS_PER_UNIT);

  sched_state_t  state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id;
  logic [IW-1:0] winner;
  logic [IW-1:0] next_id;
  logic          any_req;
  logic [CW-1:0] target;
  logic          load;
  logic          fin;
  logic          abort;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] k);
    onehot    = '0;
    onehot[k] = 1'b1;
  endfunction

  // Search starts at ptr so the most recently served requester is checked last.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && req[(int'(ptr) + i) % NREQ]) begin
        any_req = 1'b1;
        winner  = IW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign target  = CW'(dur[int'(winner)*W +: W]) * CW'(TICKS_PER_UNIT);
  assign next_id = (id == IW'(NREQ - 1)) ? '0 : id + IW'(1);
  assign load    = (state == IDLE) && any_req && (target != '0);

`ifdef TIMER_SCHED_ABORT_EN
  assign abort = (state == RUN) && !req[id];
`else
  assign abort = 1'b0;
`endif

  interval_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .target (target),
    .load   (load),
    .en     ((state == RUN) && !fin),
    .fin    (fin)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      grant     <= '0;
      done      <= '0;
      active_id <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            id        <= winner;
            grant     <= onehot(winner);
            active_id <= winner;
            busy      <= 1'b1;
            if (target != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= onehot(winner);
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            ptr       <= next_id;
            grant     <= '0;
            active_id <= '0;
            busy      <= 1'b0;
          end else if (fin) begin
            state <= DONE;
            done  <= onehot(id);
          end
        end
        DONE: begin
          state     <= IDLE;
          ptr       <= next_id;
          grant     <= '0;
          done      <= '0;
          active_id <= '0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          grant     <= '0;
          done      <= '0;
          active_id <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Round-robin scheduler that shares a single interval timer among `NREQ` requesters. Each requester asks for a delay in units of `TICKS_PER_UNIT` clock cycles (100 ns at a 100 MHz clock with the default of 10). The scheduler grants the timer to one requester at a time, runs the full interval, then returns a one-cycle `done` pulse to that requester. It sits between the lab's control FSMs and the one shared delay counter, so each FSM does not need its own timer.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 4: width of each requested duration, in units.
- `TICKS_PER_UNIT`, 10: clock cycles per duration unit.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  NREQ  level request per requester; held high until `done` is seen.
- `dur`  in  NREQ*W  flat duration bus; slice i is `dur[i*W +: W]`.
- `grant`  out  NREQ  one-hot; the requester currently owning the timer.
- `done`  out  NREQ  one-hot, one-cycle pulse marking interval completion.
- `active_id`  out  $clog2(NREQ)  index of the granted requester; 0 when idle.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states are IDLE, RUN and DONE. All outputs are registered or decoded from registered state only.
- **IDLE**
  - If any `req` is high, pick a winner by round-robin search starting at `ptr`, latch its id, and latch target T = dur_i × TICKS_PER_UNIT.
  - If T ≠ 0, load count = 1 and go to RUN.
  - If T = 0, go directly to DONE.
- **RUN**
  - count increments each cycle.
  - When count == T, go to DONE.
- **DONE**
  - Assert `done[id]` for exactly one cycle.
  - Set `ptr` = id+1 mod NREQ, so the last served requester becomes lowest priority.
  - Go to IDLE.
- `grant[id]` is high throughout RUN and DONE; `grant` is 0 in IDLE.
- `dur` is sampled only at the IDLE→RUN/DONE transition. Later changes to `dur` are ignored until the next grant.
- The requester must drop `req` in the cycle after `done`. If `req` is still high in IDLE, it is treated as a new request, arbitrated normally.
- Arithmetic: the counter and T are W + $clog2(TICKS_PER_UNIT+1) bits wide, so the product never truncates.
- Reset (at any time, including mid-RUN):
  - state = IDLE, ptr = 0, count = 0.
  - `grant`, `done`, `active_id` and `busy` all go to 0.
  - No `done` is issued for the aborted interval.

## Timing
- Cycle 0: IDLE samples `req` high.
- Cycles 1..T: RUN with `grant` high.
- Cycle T+1: DONE; `grant` and `done` both high.
- Cycle T+2: IDLE.
- For T = 0: `grant` and `done` are both high in cycle 1 only.
- Back-to-back requests: the next winner is arbitrated in the IDLE cycle after DONE. This gives one idle cycle between grants.
- Maximum interval is (2^W − 1)·TICKS_PER_UNIT + 1 cycles of grant.

## Configuration
- Macro: `TIMER_SCHED_ABORT_EN`.
- Defined:
  - If the granted requester drops `req` during RUN, the FSM returns to IDLE on the next edge.
  - No `done` is issued.
  - `ptr` advances past the aborted requester.
- Undefined:
  - A `req` drop during RUN is ignored.
  - The interval completes and `done` pulses normally.

## Structure
- Package `timer_sched_pkg`:
  - state enum `sched_state_t` (IDLE, RUN, DONE);
  - a default-ticks constant `TICKS_100NS` = 10;
  - a helper function for the counter width.
- Sub-module `interval_timer`:
  - load/enable counter with a terminal-count flag;
  - inputs: target, load, en;
  - output: fin.
- The top level contains the arbiter, the FSM and the output registers.

## Test plan
- Defaults (NREQ=4, W=4, TICKS=10), `req[1]` with dur=1:
  - `grant[1]` high in cycles 1–11;
  - `done[1]` pulses in cycle 11 only;
  - `busy` falls in cycle 12.
- `req[0]` and `req[2]` asserted together, dur=2 each:
  - 0 is granted first, with `done[0]` at cycle 21;
  - 2 is granted from cycle 23, with `done[2]` at cycle 43.
- All four `req` held continuously, re-raised after each `done`, dur=1:
  - grant order is 0,1,2,3,0;
  - no requester is granted twice in a row.
- `req[3]` with dur=0:
  - `grant[3]` and `done[3]` are both high in cycle 1 only;
  - back to IDLE in cycle 2.
- `req[0]` with dur=15:
  - `done` arrives at cycle 151, confirming no width overflow.
- `reset` pulsed at cycle 5 of a dur=3 run:
  - all outputs go to 0 immediately;
  - no `done` is issued;
  - a fresh request afterwards is granted with ptr=0 priority.
- With `TIMER_SCHED_ABORT_EN`, `req[1]` dropped at cycle 4 of a dur=2 run:
  - no `done`;
  - `grant` is 0 from cycle 5.
